// File: rtl/uart_rx_if.sv
// Purpose: bundles the serial-side inputs and received-word outputs of uart_rx.
// Latency: none (wires only).
// Backpressure: none; rx_done is a strobe and the consumer must take it in the pulse cycle.
//
// Signals:
//   b_tick    - one-clk pulse at OSV_RATE x baud rate
//   rx        - asynchronous serial line, idle high
//   rx_data   - last received word, held until the next frame completes
//   rx_done   - one-clk strobe when rx_data / frame_err update
//   rx_busy   - high while a frame is being received
//   frame_err - stop bit of the last frame was low
interface uart_rx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  b_tick;
    logic                  rx;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_done;
    logic                  rx_busy;
    logic                  frame_err;

    // master drives the line and tick; slave is the receiver
    modport master (
        output b_tick, rx,
        input  rx_data, rx_done, rx_busy, frame_err
    );

    modport slave (
        input  b_tick, rx,
        output rx_data, rx_done, rx_busy, frame_err
    );
endinterface

// File: rtl/uart_rx.sv
// Purpose: oversampling UART receiver (start qualify, mid-bit sampling LSB first, stop check).
// Latency: 3 clk from falling rx to START; START to rx_done is OSV_RATE/2 + DATA_WIDTH*OSV_RATE + OSV_RATE b_ticks.
// Backpressure: none; each frame produces one rx_done strobe regardless of the consumer.
//
// Ports:
//   clk - rising-edge system clock
//   rst - synchronous active-high reset
//   bus - uart_rx_if slave: b_tick, rx in; rx_data, rx_done, rx_busy, frame_err out
// DATA_WIDTH must be >= 2; OSV_RATE must be even and >= 4.
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int OSV_RATE   = 16
) (
    input  logic      clk,
    input  logic      rst,
    uart_rx_if.slave  bus
);

    localparam int TW = (OSV_RATE   > 1) ? $clog2(OSV_RATE)   : 1;
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [TW-1:0] TICK_HALF = TW'(OSV_RATE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OSV_RATE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    state_e                state_q,     state_d;
    logic                  rx_meta_q,   rx_meta_d;
    logic                  rx_s_q,      rx_s_d;
    logic [TW-1:0]         tickcnt_q,   tickcnt_d;
    logic [BW-1:0]         bitcnt_q,    bitcnt_d;
    logic [DATA_WIDTH-1:0] shreg_q,     shreg_d;
    logic [DATA_WIDTH-1:0] rx_data_q,   rx_data_d;
    logic                  rx_done_q,   rx_done_d;
    logic                  rx_busy_q,   rx_busy_d;
    logic                  frame_err_q, frame_err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            // synchronizer resets to the idle line level so reset never looks like a start bit
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= IDLE;
            tickcnt_q   <= '0;
            bitcnt_q    <= '0;
            shreg_q     <= '0;
            rx_data_q   <= '0;
            rx_done_q   <= 1'b0;
            rx_busy_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_meta_q   <= rx_meta_d;
            rx_s_q      <= rx_s_d;
            state_q     <= state_d;
            tickcnt_q   <= tickcnt_d;
            bitcnt_q    <= bitcnt_d;
            shreg_q     <= shreg_d;
            rx_data_q   <= rx_data_d;
            rx_done_q   <= rx_done_d;
            rx_busy_q   <= rx_busy_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        rx_meta_d   = bus.rx;
        rx_s_d      = rx_meta_q;
        state_d     = state_q;
        tickcnt_d   = tickcnt_q;
        bitcnt_d    = bitcnt_q;
        shreg_d     = shreg_q;
        rx_data_d   = rx_data_q;
        rx_done_d   = 1'b0;
        frame_err_d = frame_err_q;

        unique case (state_q)
            IDLE: begin
                tickcnt_d = '0;
                bitcnt_d  = '0;
                // no tick needed: start the half-bit count as soon as the line drops
                if (!rx_s_q) begin
                    state_d = START;
                end
            end

            START: begin
                if (bus.b_tick) begin
                    if (tickcnt_q == TICK_HALF) begin
                        // mid start bit: still low means a real start, high means a glitch
                        tickcnt_d = '0;
                        state_d   = rx_s_q ? IDLE : DATA;
                    end else begin
                        tickcnt_d = tickcnt_q + 1'b1;
                    end
                end
            end

            DATA: begin
                if (bus.b_tick) begin
                    if (tickcnt_q == TICK_LAST) begin
                        // one full bit after the previous mid-bit point: LSB arrives first
                        tickcnt_d = '0;
                        shreg_d   = {rx_s_q, shreg_q[DATA_WIDTH-1:1]};
                        if (bitcnt_q == BIT_LAST) begin
                            bitcnt_d = '0;
                            state_d  = STOP;
                        end else begin
                            bitcnt_d = bitcnt_q + 1'b1;
                        end
                    end else begin
                        tickcnt_d = tickcnt_q + 1'b1;
                    end
                end
            end

            STOP: begin
                if (bus.b_tick) begin
                    if (tickcnt_q == TICK_LAST) begin
                        // publish at mid stop bit so a following start edge is not missed
                        rx_data_d   = shreg_q;
                        frame_err_d = ~rx_s_q;
                        rx_done_d   = 1'b1;
                        tickcnt_d   = '0;
                        state_d     = IDLE;
                    end else begin
                        tickcnt_d = tickcnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // registered copy of "not idle", so it tracks the state register edge for edge
        rx_busy_d = (state_d != IDLE);
    end

    assign bus.rx_data   = rx_data_q;
    assign bus.rx_done   = rx_done_q;
    assign bus.rx_busy   = rx_busy_q;
    assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Purpose: directed self-checking bench for uart_rx with a bit-banged transmitter model.
// Latency: b_tick every TICK_DIV clk, so one bit is BIT_CLK clk on the receiver side.
// Backpressure: none; every rx_done is captured into a queue as {frame_err, rx_data}.
module tb_uart_rx;

    localparam int DW       = 8;
    localparam int OSV      = 16;
    localparam int TICK_DIV = 8;
    localparam int BIT_CLK  = OSV * TICK_DIV;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    uart_rx_if #(.DATA_WIDTH(DW)) bus ();

    uart_rx #(
        .DATA_WIDTH (DW),
        .OSV_RATE   (OSV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // baud tick generator: inputs change 1 time unit after the rising edge
    initial begin
        bus.b_tick = 1'b0;
        forever begin
            for (int i = 0; i < TICK_DIV; i++) begin
                @(posedge clk);
                #1;
                bus.b_tick = (i == TICK_DIV - 1);
            end
        end
    end

    // output monitor, sampled on the falling edge
    logic [8:0] dq[$];
    int         busy_ticks = 0;
    bit         busy_seen  = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (bus.rx_done === 1'b1) dq.push_back({bus.frame_err, bus.rx_data});
            if (bus.rx_busy === 1'b1) begin
                busy_seen = 1'b1;
                if (bus.b_tick === 1'b1) busy_ticks++;
            end
        end
    end

    function automatic logic [8:0] q_at(input int i);
        if (i < dq.size()) return dq[i];
        return 9'bx;
    endfunction

    task automatic check_rx(input string tag, input int idx, input logic [7:0] d, input logic fe);
        logic [8:0] e;
        e = q_at(idx);
        check({tag, "_data"}, {24'd0, e[7:0]}, {24'd0, d});
        check({tag, "_ferr"}, {31'd0, e[8]}, {31'd0, fe});
    endtask

    // called and returns at posedge+1
    task automatic hold(input logic v, input int n);
        bus.rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input int bclk, input int stop_clk, input logic stop_val);
        hold(1'b0, bclk);
        for (int i = 0; i < DW; i++) hold(d[i], bclk);
        hold(stop_val, stop_clk);
        bus.rx = 1'b1;
    endtask

    task automatic idle(input int n_bits);
        hold(1'b1, n_bits * BIT_CLK);
    endtask

    logic [7:0] b2b [3] = '{8'h00, 8'hFF, 8'h3C};

    initial begin
        rst    = 1'b1;
        bus.rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_rx_data",   {24'd0, bus.rx_data},   32'h0);
        check("rst_rx_done",   {31'd0, bus.rx_done},   32'h0);
        check("rst_rx_busy",   {31'd0, bus.rx_busy},   32'h0);
        check("rst_frame_err", {31'd0, bus.frame_err}, 32'h0);
        @(posedge clk);
        #1;

        // single nominal frame
        dq.delete();
        busy_ticks = 0;
        send_frame(8'hA5, BIT_CLK, BIT_CLK, 1'b1);
        idle(2);
        check("a5_count", dq.size(), 1);
        check_rx("a5", 0, 8'hA5, 1'b0);
        check("a5_busy_ticks", busy_ticks, 152);

        // back-to-back frames, single stop bit, no gap
        dq.delete();
        for (int k = 0; k < 3; k++) send_frame(b2b[k], BIT_CLK, BIT_CLK, 1'b1);
        idle(2);
        check("b2b_count", dq.size(), 3);
        check_rx("b2b0", 0, 8'h00, 1'b0);
        check_rx("b2b1", 1, 8'hFF, 1'b0);
        check_rx("b2b2", 2, 8'h3C, 1'b0);

        // glitch shorter than half a bit
        dq.delete();
        busy_seen = 1'b0;
        hold(1'b0, 3 * TICK_DIV);
        idle(2);
        check("glitch_count", dq.size(), 0);
        check("glitch_rx_data", {24'd0, bus.rx_data}, 32'h3C);
        check("glitch_busy_seen", {31'd0, busy_seen}, 32'h1);
        check("glitch_busy_clear", {31'd0, bus.rx_busy}, 32'h0);

        // framing error; the low stop bit is 3/4 bit long so the line is high again
        // when the restarted START qualifies, keeping the outcome deterministic
        dq.delete();
        send_frame(8'h55, BIT_CLK, (BIT_CLK * 3) / 4, 1'b0);
        idle(2);
        check("ferr_level", {31'd0, bus.frame_err}, 32'h1);
        check("ferr_busy_clear", {31'd0, bus.rx_busy}, 32'h0);
        send_frame(8'h12, BIT_CLK, BIT_CLK, 1'b1);
        idle(2);
        check("ferr_count", dq.size(), 2);
        check_rx("ferr55", 0, 8'h55, 1'b1);
        check_rx("ferr12", 1, 8'h12, 1'b0);

        // reset in the middle of data bit 4 of 0xC3
        fork
            send_frame(8'hC3, BIT_CLK, BIT_CLK, 1'b1);
            begin
                repeat (5 * BIT_CLK + BIT_CLK / 2) @(posedge clk);
                #1;
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                @(negedge clk);
                check("mrst_rx_data",   {24'd0, bus.rx_data},   32'h0);
                check("mrst_rx_done",   {31'd0, bus.rx_done},   32'h0);
                check("mrst_rx_busy",   {31'd0, bus.rx_busy},   32'h0);
                check("mrst_frame_err", {31'd0, bus.frame_err}, 32'h0);
            end
        join
        // let any frame started from the remains of 0xC3 drain before 0x81
        idle(12);
        dq.delete();
        send_frame(8'h81, BIT_CLK, BIT_CLK, 1'b1);
        idle(2);
        check("post_rst_count", dq.size(), 1);
        check_rx("post_rst", 0, 8'h81, 1'b0);

        // transmitter bit period about 3% fast, then about 3% slow
        dq.delete();
        for (int k = 0; k < 3; k++) send_frame(8'h96, BIT_CLK - 4, BIT_CLK - 4, 1'b1);
        for (int k = 0; k < 3; k++) send_frame(8'h96, BIT_CLK + 4, BIT_CLK + 4, 1'b1);
        idle(2);
        check("tol_count", dq.size(), 6);
        for (int k = 0; k < 6; k++) check_rx($sformatf("tol%0d", k), k, 8'h96, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
